// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with programmable modulus and synchronous load.
// Define UDC_SATURATE_EN to make boundary steps saturate instead of wrap.
module param_updown_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 49999999,
  parameter int DIV_W = 26
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam logic [DIV_W-1:0] DIV_V = DIV_W'(DIV);

  logic [DIV_W-1:0] presc;
  logic             step;
  logic [WIDTH-1:0] q_step;
  logic             tc_step;
  logic [WIDTH-1:0] q_load;

  assign step   = en && (presc == DIV_V);
  assign q_load = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    q_step  = q;
    tc_step = 1'b0;
    unique case (1'b1)
      mode == 2'b01: begin
        if (q >= max_val) begin
`ifdef UDC_SATURATE_EN
          q_step = max_val;
`else
          q_step = '0;
`endif
          tc_step = 1'b1;
        end else begin
          q_step = q + WIDTH'(1);
        end
      end
      mode == 2'b10: begin
        if (q == '0) begin
`ifdef UDC_SATURATE_EN
          q_step = '0;
`else
          q_step = max_val;
`endif
          tc_step = 1'b1;
        end else if (q > max_val) begin
          // out-of-range value left by a max_val change: clamp, no tc
          q_step = max_val;
        end else begin
          q_step = q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      q     <= '0;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else if (load) begin
      q     <= q_load;
      presc <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step & tc_step;
      if (en)
        presc <= step ? '0 : presc + DIV_W'(1);
      if (step)
        q <= q_step;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, DIV=3).
// Randomized and directed stimulus against a behavioural model.
module tb_param_updown_counter;

  localparam int W     = 4;
  localparam int DIV   = 3;
  localparam int DIV_W = 4;
`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         resetn;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] max_val;
  logic [W-1:0] q;
  logic         tick;
  logic         tc;

  int checks = 0;
  int errors = 0;

  int m_q;
  int m_p;
  bit m_tick;
  bit m_tc;

  param_updown_counter #(
    .WIDTH(W), .DIV(DIV), .DIV_W(DIV_W)
  ) dut (
    .clk_in(clk_in), .resetn(resetn), .en(en),
    .mode(mode), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q), .tick(tick), .tc(tc)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    m_q = 0; m_p = 0; m_tick = 0; m_tc = 0;
  endfunction

  // one rising edge of the reference behaviour
  function automatic void model_edge();
    int mx = int'(max_val);
    bit st = 0;
    m_tick = 0;
    m_tc   = 0;
    if (load) begin
      m_q = (int'(load_val) < mx) ? int'(load_val) : mx;
      m_p = 0;
      return;
    end
    if (!en) return;
    if (m_p == DIV) begin m_p = 0; st = 1; end
    else m_p = m_p + 1;
    if (!st) return;
    m_tick = 1;
    if (mode == 2'd1) begin
      if (m_q < mx) m_q = m_q + 1;
      else begin m_q = SAT ? mx : 0; m_tc = 1; end
    end else if (mode == 2'd2) begin
      if (m_q == 0) begin m_q = SAT ? 0 : mx; m_tc = 1; end
      else if (m_q > mx) m_q = mx;
      else m_q = m_q - 1;
    end
  endfunction

  task automatic clk_edge();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic do_load(input int lv, input int mx);
    load = 1; load_val = W'(lv); max_val = W'(mx);
    clk_edge();
    load = 0;
  endtask

  task automatic test_reset();
    resetn = 0; en = 0; mode = 0; load = 0;
    load_val = 0; max_val = 0;
    model_reset();
    #1;
    checks++;
    if ({q, tick, tc} !== {W'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset q/tick/tc got %0d/%b/%b want 0/0/0", q, tick, tc);
    end
    @(posedge clk_in); #2;
    resetn = 1;
  endtask

  task automatic test_up_count();
    int ntc = 0;
    int first = -1;
    resetn = 0; #1; model_reset(); #1; resetn = 1;
    en = 1; mode = 2'd1; max_val = 4'd15;
    for (int i = 1; i <= 68; i++) begin
      clk_edge();
      if (tc) ntc++;
      if (tick && first < 0) first = i;
      checks++;
      if ({q, tick, tc} !== {W'(m_q), m_tick, m_tc}) begin
        errors++;
        $display("FAIL up cyc %0d q/tick/tc got %0d/%b/%b want %0d/%b/%b",
                 i, q, tick, tc, m_q, m_tick, m_tc);
      end
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL up_first_tick got %0d want 4", first);
    end
    checks++;
    if (ntc !== (SAT ? 2 : 1)) begin
      errors++;
      $display("FAIL up_tc_count got %0d want %0d", ntc, SAT ? 2 : 1);
    end
    checks++;
    if (q !== (SAT ? W'(15) : W'(1))) begin
      errors++;
      $display("FAIL up_final q got %0d want %0d", q, SAT ? 15 : 1);
    end
  endtask

  task automatic test_down_count();
    int ntc = 0;
    en = 1; mode = 2'd0;
    do_load(0, 9);
    mode = 2'd2;
    for (int i = 1; i <= 40; i++) begin
      clk_edge();
      if (tc) ntc++;
      checks++;
      if ({q, tick, tc} !== {W'(m_q), m_tick, m_tc}) begin
        errors++;
        $display("FAIL down cyc %0d q/tick/tc got %0d/%b/%b want %0d/%b/%b",
                 i, q, tick, tc, m_q, m_tick, m_tc);
      end
    end
    checks++;
    if (ntc !== (SAT ? 10 : 1) || q !== W'(0)) begin
      errors++;
      $display("FAIL down_end tc_count/q got %0d/%0d want %0d/0",
               ntc, q, SAT ? 10 : 1);
    end
  endtask

  task automatic test_load_priority();
    en = 1; mode = 2'd1;
    do_load(7, 15);
    for (int i = 0; i < 3; i++) clk_edge();
    load = 1; load_val = 4'd5;
    clk_edge();
    load = 0;
    checks++;
    if ({q, tick, tc} !== {W'(5), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_prio q/tick/tc got %0d/%b/%b want 5/0/0", q, tick, tc);
    end
    for (int i = 1; i <= 4; i++) begin
      clk_edge();
      checks++;
      if ({q, tick} !== {(i == 4) ? W'(6) : W'(5), i == 4}) begin
        errors++;
        $display("FAIL load_resume cyc %0d q/tick got %0d/%b want %0d/%b",
                 i, q, tick, (i == 4) ? 6 : 5, i == 4);
      end
    end
  endtask

  task automatic test_load_clamp();
    en = 1; mode = 2'd0;
    do_load(12, 9);
    checks++;
    if (q !== W'(9)) begin
      errors++;
      $display("FAIL load_clamp q got %0d want 9", q);
    end
    mode = 2'd1;
    for (int i = 0; i < 4; i++) clk_edge();
    checks++;
    if ({q, tick, tc} !== {SAT ? W'(9) : W'(0), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clamp_step q/tick/tc got %0d/%b/%b want %0d/1/1",
               q, tick, tc, SAT ? 9 : 0);
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    en = 1; mode = 2'd1;
    do_load(11, 15);
    clk_edge();
    clk_edge();
    #3;
    resetn = 0;
    model_reset();
    #1;
    checks++;
    if ({q, tick, tc} !== {W'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset q/tick/tc got %0d/%b/%b want 0/0/0", q, tick, tc);
    end
    @(posedge clk_in); #3;
    resetn = 1;
    for (int i = 1; i <= 8; i++) begin
      clk_edge();
      if (tick && first < 0) first = i;
      checks++;
      if ({q, tick, tc} !== {W'(m_q), m_tick, m_tc}) begin
        errors++;
        $display("FAIL restart cyc %0d q/tick/tc got %0d/%b/%b want %0d/%b/%b",
                 i, q, tick, tc, m_q, m_tick, m_tc);
      end
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL restart_first_tick got %0d want 4", first);
    end
  endtask

  task automatic test_max_zero();
    int ntc = 0;
    en = 1; mode = 2'd0;
    do_load(3, 0);
    for (int i = 0; i < 24; i++) begin
      mode = (i < 12) ? 2'd1 : 2'd2;
      clk_edge();
      if (tc) ntc++;
      checks++;
      if ({q, tick, tc} !== {W'(0), m_tick, m_tick}) begin
        errors++;
        $display("FAIL max_zero cyc %0d q/tick/tc got %0d/%b/%b want 0/%b/%b",
                 i, q, tick, tc, m_tick, m_tick);
      end
    end
    checks++;
    if (ntc !== 6) begin
      errors++;
      $display("FAIL max_zero_tc_count got %0d want 6", ntc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom);
      load = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 31) == 0) max_val = W'($urandom);
      clk_edge();
      checks++;
      if ({q, tick, tc} !== {W'(m_q), m_tick, m_tc}) begin
        errors++;
        $display("FAIL random cyc %0d q/tick/tc got %0d/%b/%b want %0d/%b/%b",
                 i, q, tick, tc, m_q, m_tick, m_tc);
      end
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load_priority();
    test_load_clamp();
    test_async_reset();
    test_max_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, 4, counter width in bits (>=2).
REQ-002 Parameter DIV, 49999999, prescaler terminal value; one count step every DIV+1 clk_in cycles (DIV=0 gives a step every cycle).
REQ-003 Parameter DIV_W, 26, prescaler register width; SHALL satisfy 2**DIV_W > DIV.
REQ-004 clk_in  input  1  system clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  prescaler run enable.
REQ-007 mode  input  2  00 hold, 01 up, 10 down, 11 hold.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  load value.
REQ-010 max_val  input  WIDTH  upper count limit (modulus max_val+1).
REQ-011 q  output  WIDTH  registered count.
REQ-012 tick  output  1  registered one-cycle pulse marking a prescaler step.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-014 The block SHALL be fully synchronous to clk_in; no derived or gated clocks.
REQ-015 Prescaler: when en=1, presc increments each cycle; at presc==DIV, next edge sets presc=0 and internal step=1 for that edge; en=0 holds presc.
REQ-016 tick SHALL be 1 in the cycle following a step edge, 0 otherwise, independent of mode.
REQ-017 Step with mode 01: q<max_val -> q+1; q>=max_val -> q=0, tc=1.
REQ-018 Step with mode 10: 0<q<=max_val -> q-1; q==0 -> q=max_val, tc=1; q>max_val -> q=max_val, tc=0.
REQ-019 Step with mode 00/11: q holds, tc=0.
REQ-020 load=1 SHALL take priority over any step: q=min(load_val,max_val), presc=0, tick=0, tc=0 on that edge.
REQ-021 tc and tick SHALL be 0 on every edge with no step; neither SHALL exceed one cycle wide.
REQ-022 max_val changes take effect on the next step; q is not corrected until then.
REQ-023 max_val=0: up and down steps keep q=0 and pulse tc every step.
REQ-024 Arithmetic SHALL be modulo 2**WIDTH internally; no step SHALL leave q outside 0..max_val unless loaded or reconfigured so.

Reset
REQ-025 resetn low SHALL immediately force q=0, presc=0, tick=0, tc=0, regardless of clk_in.
REQ-026 After resetn deasserts, first step SHALL occur DIV+1 enabled cycles later.
REQ-027 Reset asserted mid-count SHALL discard partial prescaler progress.

Configuration
REQ-028 Macro UDC_SATURATE_EN selects boundary behaviour.
REQ-029 Undefined: wrap per REQ-017/REQ-018.
REQ-030 Defined: up at q>=max_val sets q=max_val; down at q==0 keeps q=0; tc=1 on each such blocked step; all other behaviour unchanged.

Verification (DIV=3, WIDTH=4)
REQ-031 Reset, en=1, mode=01, max_val=15 -> q 0,1,...,15,0 changing every 4 cycles; tick every 4 cycles; tc single pulse with 15->0.
REQ-032 max_val=9, mode=10 from q=0 -> q 9,8,...,0,9; tc pulse only on 0->9.
REQ-033 At q=7, load=1 load_val=5 one cycle before a step -> q=5 next edge, no step, next step 4 cycles later to 6.
REQ-034 max_val=9, load_val=12 -> q=9; then mode=01 step -> q=0, tc=1.
REQ-035 resetn pulsed low between edges at q=11 -> q=0 immediately, tick/tc 0; restart steps 4 cycles after release.
REQ-036 UDC_SATURATE_EN defined, mode=01, max_val=15 -> q reaches 15 and stays; tc=1 on every later step.
